// File: rtl/adc_pwrup_seq_if.sv
// Control/ADC-pin bundle for the ADC power-up sequencer.
// The adc_drdy_n pin exists only when PWRUP_WATCHDOG_EN is defined.
interface adc_pwrup_seq_if;
  logic start;
  logic abort;
  logic adc_pwdn_n;
  logic adc_rst_n;
  logic busy;
  logic ready;
  logic err;
`ifdef PWRUP_WATCHDOG_EN
  logic adc_drdy_n;
`endif

  // Top-level control FSM side: issues requests, observes status and pins.
  modport master (
    output start,
    output abort,
    input  adc_pwdn_n,
    input  adc_rst_n,
    input  busy,
    input  ready,
    input  err
  );

  // Sequencer side: takes requests (and DRDY), drives status and ADC pins.
  modport slave (
    input  start,
    input  abort,
`ifdef PWRUP_WATCHDOG_EN
    input  adc_drdy_n,
`endif
    output adc_pwdn_n,
    output adc_rst_n,
    output busy,
    output ready,
    output err
  );
endinterface

// File: rtl/adc_pwrup_seq.sv
// ADC power-up sequencer: releases power-down, holds reset for N_PWR cycles,
// releases reset, waits N_WAKE cycles, then reports ready.
// Optional feature macro: PWRUP_WATCHDOG_EN adds a DRDY wait state with an
// N_WD-cycle watchdog that falls into ERROR when DRDY never asserts.
module adc_pwrup_seq #(
  parameter int FREQ_MHZ  = 50,
  parameter int T_PWR_US  = 1000,
  parameter int T_WAKE_US = 100,
  parameter int T_WD_US   = 500
) (
  input  logic            clk,
  input  logic            rst_l,
  adc_pwrup_seq_if.slave  bus
);

  localparam int N_PWR  = FREQ_MHZ * T_PWR_US;
  localparam int N_WAKE = FREQ_MHZ * T_WAKE_US;
  localparam int N_WD   = FREQ_MHZ * T_WD_US;
  localparam int N_MAX  = (N_PWR > N_WAKE) ? ((N_PWR > N_WD) ? N_PWR : N_WD)
                                           : ((N_WAKE > N_WD) ? N_WAKE : N_WD);
  localparam int CNT_W  = $clog2(N_MAX + 1);

  localparam logic [CNT_W-1:0] LOAD_PWR  = CNT_W'(N_PWR - 1);
  localparam logic [CNT_W-1:0] LOAD_WAKE = CNT_W'(N_WAKE - 1);
`ifdef PWRUP_WATCHDOG_EN
  localparam logic [CNT_W-1:0] LOAD_WD   = CNT_W'(N_WD - 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PWR   = 3'd1,
    WAKE  = 3'd2,
    DRDY  = 3'd3,
    READY = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // State and counter register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; abort overrides everything else.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = PWR;
            cnt_d   = LOAD_PWR;
          end
        end
        PWR: begin
          if (cnt_zero) begin
            state_d = WAKE;
            cnt_d   = LOAD_WAKE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WAKE: begin
          if (cnt_zero) begin
`ifdef PWRUP_WATCHDOG_EN
            state_d = DRDY;
            cnt_d   = LOAD_WD;
`else
            state_d = READY;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
`ifdef PWRUP_WATCHDOG_EN
        DRDY: begin
          // DRDY on the last count still wins over the watchdog expiry.
          if (!bus.adc_drdy_n) begin
            state_d = READY;
          end else if (cnt_zero) begin
            state_d = ERROR;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ERROR: begin
          if (bus.start) begin
            state_d = PWR;
            cnt_d   = LOAD_PWR;
          end
        end
`endif
        READY: begin
          state_d = READY;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs decoded from the next state, so they move with the state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bus.adc_pwdn_n <= 1'b0;
      bus.adc_rst_n  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.ready      <= 1'b0;
    end else begin
      bus.adc_pwdn_n <= (state_d inside {PWR, WAKE, DRDY, READY});
      bus.adc_rst_n  <= (state_d inside {WAKE, DRDY, READY});
      bus.busy       <= (state_d inside {PWR, WAKE, DRDY});
      bus.ready      <= (state_d == READY);
    end
  end

`ifdef PWRUP_WATCHDOG_EN
  // Error flag register, high only while in ERROR.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) bus.err <= 1'b0;
    else        bus.err <= (state_d == ERROR);
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_pwrup_seq.sv
// Directed bench for adc_pwrup_seq with FREQ_MHZ=1, T_PWR_US=10, T_WAKE_US=5,
// T_WD_US=4. Output vector order: {pwdn_n, rst_n, busy, ready, err}.
module tb_adc_pwrup_seq;
  logic clk;
  logic rst_l;
  int   n_vec;
  int   n_err;

  adc_pwrup_seq_if bus ();

  adc_pwrup_seq #(
    .FREQ_MHZ  (1),
    .T_PWR_US  (10),
    .T_WAKE_US (5),
    .T_WD_US   (4)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_PWR   = 5'b10100;
  localparam logic [4:0] O_WAKE  = 5'b11100;
  localparam logic [4:0] O_DRDY  = 5'b11100;
  localparam logic [4:0] O_READY = 5'b11010;
  localparam logic [4:0] O_ERROR = 5'b00001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, bus.adc_pwdn_n, bus.adc_rst_n, bus.busy, bus.ready, bus.err};
  endfunction

  // Advance one edge; inputs set afterwards are sampled on the next edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller sets start=1; edge 0 is taken here. Checks PWR/WAKE boundaries and
  // ends right after edge 15. Optional start pulses at edges 3 and 12.
  task automatic expect_pwrup(input string tag, input bit pulse);
    step();
    check({tag, "_e0"}, outs(), O_PWR);
    for (int k = 1; k <= 15; k++) begin
      bus.start = pulse && (k == 3 || k == 12);
      step();
      if (k == 9)  check({tag, "_e9"},  outs(), O_PWR);
      if (k == 10) check({tag, "_e10"}, outs(), O_WAKE);
      if (k == 14) check({tag, "_e14"}, outs(), O_WAKE);
`ifdef PWRUP_WATCHDOG_EN
      if (k == 15) check({tag, "_e15"}, outs(), O_DRDY);
`else
      if (k == 15) check({tag, "_e15"}, outs(), O_READY);
`endif
    end
    bus.start = 1'b0;
  endtask

  task automatic do_abort(input string tag);
    bus.abort = 1'b1;
    step();
    check(tag, outs(), O_IDLE);
    bus.abort = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_l     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef PWRUP_WATCHDOG_EN
    bus.adc_drdy_n = 1'b1;
`endif
    step(2);
    check("reset_outs", outs(), O_IDLE);
    rst_l = 1'b1;
    step();
    check("idle_no_start", outs(), O_IDLE);

    // 1. Basic sequence; start then held high must not retrigger after READY.
    bus.start = 1'b1;
    expect_pwrup("seq", 1'b0);
`ifdef PWRUP_WATCHDOG_EN
    bus.adc_drdy_n = 1'b0;
    step();
    check("seq_drdy_ready", outs(), O_READY);
    bus.adc_drdy_n = 1'b1;
`endif
    bus.start = 1'b1;
    step(3);
    check("ready_hold_start", outs(), O_READY);
    bus.start = 1'b0;
    do_abort("ready_abort");

    // 2. Abort at edge 7 of PWR, with start also high: abort wins.
    bus.start = 1'b1;
    step();
    check("ab_e0", outs(), O_PWR);
    bus.start = 1'b0;
    step(6);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    check("ab_e7", outs(), O_IDLE);
    bus.abort = 1'b0;
    bus.start = 1'b1;
    expect_pwrup("restart", 1'b0);
    do_abort("restart_abort");

    // 3. Start pulses mid-sequence are ignored.
    bus.start = 1'b1;
    expect_pwrup("pulse", 1'b1);
    do_abort("pulse_abort");

    // 4. Async reset mid-sequence (between edges 11 and 12).
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(11);
    check("rst_pre", outs(), O_WAKE);
    #3;
    rst_l = 1'b0;
    #1;
    check("rst_async", outs(), O_IDLE);
    step(2);
    rst_l = 1'b1;
    step(3);
    check("rst_stays_idle", outs(), O_IDLE);

`ifdef PWRUP_WATCHDOG_EN
    // 5. Watchdog expiry, then retry with DRDY in cycle 2 of DRDY.
    bus.start = 1'b1;
    expect_pwrup("wd", 1'b0);
    step(3);
    check("wd_e18", outs(), O_DRDY);
    step();
    check("wd_e19_err", outs(), O_ERROR);
    step(2);
    check("wd_err_hold", outs(), O_ERROR);
    bus.start = 1'b1;
    expect_pwrup("retry", 1'b0);
    step();
    check("retry_e16", outs(), O_DRDY);
    bus.adc_drdy_n = 1'b0;
    step();
    check("retry_ready", outs(), O_READY);
    bus.adc_drdy_n = 1'b1;
    do_abort("retry_abort");

    // 6. DRDY on the final DRDY cycle: READY; with abort: IDLE.
    bus.start = 1'b1;
    expect_pwrup("last", 1'b0);
    step(3);
    bus.adc_drdy_n = 1'b0;
    step();
    check("last_ready", outs(), O_READY);
    bus.adc_drdy_n = 1'b1;
    do_abort("last_abort");
    bus.start = 1'b1;
    expect_pwrup("lastab", 1'b0);
    step(3);
    bus.adc_drdy_n = 1'b0;
    bus.abort = 1'b1;
    step();
    check("lastab_idle", outs(), O_IDLE);
    bus.adc_drdy_n = 1'b1;
    bus.abort = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
